// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - two-requester (fetch/data) arbiter onto one SRAM-like port
// Data side has fixed priority; an in-order ID FIFO routes each response to its owner.
module sram_req_arbiter #(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                 state;
  logic                   issue_id;
  logic [OUTSTANDING-1:0] id_fifo;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          fifo_cnt;
  logic [CW-1:0]          count;
  logic                   can_accept;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic                   head;

  // The issue slot counts against the in-flight limit alongside the FIFO.
  assign count      = fifo_cnt + CW'(state == ISSUE);
  assign can_accept = !reset && (state == IDLE) && (count < CW'(OUTSTANDING));

  assign data_addr_ok = can_accept & data_req;
  assign inst_addr_ok = can_accept & inst_req & ~data_req;
  assign accept       = inst_addr_ok | data_addr_ok;

  assign push = (state == ISSUE) & mem_addr_ok;
  assign pop  = !reset && mem_data_ok && (fifo_cnt != '0);
  assign head = id_fifo[rd_ptr];

  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop & head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      issue_id  <= 1'b0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_size  <= '0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      id_fifo   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= ISSUE;
            mem_req   <= 1'b1;
            issue_id  <= data_req;
            mem_wr    <= data_req ? data_wr    : inst_wr;
            mem_size  <= data_req ? data_size  : inst_size;
            mem_wstrb <= data_req ? data_wstrb : inst_wstrb;
            mem_addr  <= data_req ? data_addr  : inst_addr;
            mem_wdata <= data_req ? data_wdata : inst_wdata;
          end
        end
        ISSUE: begin
          if (mem_addr_ok) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (push) begin
        id_fifo[wr_ptr] <= issue_id;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Two-requester arbiter that shares one SRAM-like memory port between the instruction-fetch side and the data (load/store) side of the pipeline. It accepts one request at a time through a registered issue slot, forwards it downstream with a req/addr_ok handshake, and records the owner of every outstanding transaction in an in-order ID FIFO. Each downstream data_ok and rdata is routed back to the correct requester. It sits between the fetch/MEM-stage SRAM interfaces and the single external memory port or bridge.

## Interface
- OUTSTANDING, 2, max transactions in flight (issue slot plus FIFO entries); power of two, 2..8
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- inst_req / data_req  in  1  request valid
- inst_wr / data_wr  in  1  1 = write
- inst_size / data_size  in  2  0 = byte, 1 = half, 2 = word
- inst_wstrb / data_wstrb  in  4  byte enables for writes
- inst_addr / data_addr  in  32  byte address
- inst_wdata / data_wdata  in  32  write data
- inst_addr_ok / data_addr_ok  out  1  request accepted this cycle
- inst_data_ok / data_data_ok  out  1  response for this requester this cycle
- inst_rdata / data_rdata  out  32  read data, valid when the matching data_ok is high
- mem_req  out  1  downstream request valid
- mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/2/4/32/32  latched request fields
- mem_addr_ok  in  1  downstream accepted mem_req
- mem_data_ok  in  1  downstream response; responses return in request order
- mem_rdata  in  32  downstream read data

## Operation
- State IDLE / ISSUE. count = FIFO occupancy + (state == ISSUE).
- IDLE: can_accept = (count < OUTSTANDING). The winner is data if data_req, otherwise inst if inst_req. data has fixed priority over inst.
  - winner_addr_ok = can_accept & winner_req, combinational.
  - The loser's addr_ok is 0.
  - On accept, latch the winner's wr/size/wstrb/addr/wdata and its ID (0 = inst, 1 = data), then go to ISSUE.
- ISSUE: mem_req = 1 and the latched fields drive mem_*.
  - Both requester addr_ok outputs are 0.
  - On mem_addr_ok, push the latched ID into the FIFO and return to IDLE.
  - Otherwise hold, with all mem_* outputs stable.
- Response path:
  - mem_data_ok with a non-empty FIFO pops the head.
  - inst_data_ok = mem_data_ok & (head == 0).
  - data_data_ok = mem_data_ok & (head == 1).
  - inst_rdata = data_rdata = mem_rdata, passed through unconditionally.
- mem_data_ok with an empty FIFO is a protocol error: it is ignored, with no data_ok and no pointer change.
- Push and pop in the same cycle leave FIFO occupancy unchanged. Pointers wrap modulo FIFO depth.
- FIFO depth = OUTSTANDING. ID width is 1.

## Timing
- Reset values:
  - state IDLE, FIFO empty, pointers 0.
  - mem_req 0; mem_wr/size/wstrb/addr/wdata 0.
  - All data_ok outputs 0. addr_ok outputs 0 for as long as reset is asserted.
- Accept to mem_req: 1 cycle (accept in cycle N, mem_req high in N+1).
- Peak throughput: one request per 2 cycles.
- Slot freeing: count is sampled from registers, so a pop in cycle N frees a slot for acceptance only in N+1.
- Reset asserted mid-ISSUE or with transactions outstanding:
  - mem_req is 0 the next cycle and the FIFO is emptied.
  - Responses arriving after reset are ignored.
- data_ok is combinational from mem_data_ok (0-cycle routing latency).

## Test plan
- Reset: hold reset 3 cycles with inst_req = data_req = 1 -> all addr_ok and data_ok are 0, and mem_req = 0. After release, data_addr_ok = 1 in the first cycle.
- Single fetch: inst_req with addr 0x1c000000, size 2, in cycle 0 -> inst_addr_ok in cycle 0; mem_req = 1 with mem_addr = 0x1c000000 in cycle 1; mem_addr_ok in cycle 1. mem_data_ok with rdata 0x02800c0c in cycle 3 -> inst_data_ok = 1, inst_rdata = 0x02800c0c, data_data_ok = 0.
- Conflict: inst_req and data_req (store, addr 0x8, wstrb 0xf, wdata 0x12345678) both in cycle 0 -> data_addr_ok = 1 and inst_addr_ok = 0. mem carries the store fields in cycle 1. inst is accepted in cycle 2 (inst_req held) and its mem_req follows in cycle 3.
- Routing order: issue inst then data, then return mem_data_ok twice with 0xAAAA0000 then 0xBBBB0000 -> inst_data_ok carries 0xAAAA0000 first, then data_data_ok carries 0xBBBB0000.
- Full (OUTSTANDING = 2, no responses): two requests accepted; a third inst_req is not acknowledged. mem_data_ok in cycle N -> third request accepted in cycle N+1, not in N.
- Backpressure and reset: mem_addr_ok withheld for 3 cycles -> mem_addr/wdata/wstrb stable throughout. Reset asserted in the second stall cycle -> mem_req = 0 in the next cycle. A later mem_data_ok produces no data_ok.
